// File: rtl/fifo_param_amisha.sv
// Parameterised synchronous FIFO: first-word-fall-through head, registered
// occupancy count with derived status flags, and sticky overflow/underflow flags.
module fifo_param_amisha #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1
) (
    input  logic                  clk_amisha,
    input  logic                  reset_amisha,
    input  logic                  wr_amisha,
    input  logic                  rd_amisha,
    input  logic [DATA_WIDTH-1:0] w_data_amisha,
    input  logic                  clr_err_amisha,
    output logic [DATA_WIDTH-1:0] r_data_amisha,
    output logic                  empty_amisha,
    output logic                  full_amisha,
    output logic                  almost_empty_amisha,
    output logic                  almost_full_amisha,
    output logic [ADDR_WIDTH:0]   count_amisha,
    output logic                  overflow_amisha,
    output logic                  underflow_amisha
);

    localparam int                DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_en, rd_en;

    // Flags come from the registered count only, never from this cycle's requests.
    assign empty_amisha        = (count_q == '0);
    assign full_amisha         = (count_q == FULL_CNT);
    assign almost_full_amisha  = (int'(count_q) >= DEPTH - AF_MARGIN);
    assign almost_empty_amisha = (int'(count_q) <= AE_MARGIN);
    assign count_amisha        = count_q;
    assign overflow_amisha     = ovf_q;
    assign underflow_amisha    = unf_q;
    assign r_data_amisha       = mem_q[rd_ptr_q];

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign wr_en = wr_amisha && (!full_amisha || rd_amisha);
    assign rd_en = rd_amisha && !empty_amisha;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
            default: count_d = count_q;
        endcase
        ovf_d = (ovf_q && !clr_err_amisha) || (wr_amisha && full_amisha && !rd_amisha);
        unf_d = (unf_q && !clr_err_amisha) || (rd_amisha && empty_amisha);
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_amisha) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately left out of reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk_amisha) begin
        if (reset_amisha && wr_en) begin
            mem_q[wr_ptr_q] <= w_data_amisha;
        end
    end

endmodule
